// File: rtl/event_fifo_irq_pkg.sv
// Shared definitions for the event FIFO with hysteresis interrupt.
// Provides the default pointer width, the event word type and the
// interrupt FSM state encoding.
package event_fifo_irq_pkg;

  localparam int FIFO_AWIDTH    = 10;
  localparam int EVT_DATA_WIDTH = 16;

  // Encoded DVS event word (x, y, polarity packed by the encoder).
  typedef logic [EVT_DATA_WIDTH-1:0] evt_word_t;

  typedef enum logic {
    IRQ_IDLE     = 1'b0,
    IRQ_ASSERTED = 1'b1
  } irq_state_e;

endpackage

// File: rtl/event_fifo_irq_if.sv
// Event write handshake between the event encoder and the event FIFO.
//   evt_valid : encoder has an event
//   evt_data  : event word
//   evt_ready : FIFO accepts evt_data this cycle
// master = encoder side, slave = FIFO side.
interface event_fifo_irq_if
  import event_fifo_irq_pkg::*;
#(
  parameter int DATA_WIDTH = EVT_DATA_WIDTH
);

  logic                  evt_valid;
  logic [DATA_WIDTH-1:0] evt_data;
  logic                  evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/event_fifo_mem.sv
// Storage array for the event FIFO: 2**AWIDTH x DATA_WIDTH words,
// synchronous write port, asynchronous read port. Kept separate so it can
// be swapped for an SRAM macro.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module event_fifo_mem
  import event_fifo_irq_pkg::*;
#(
  parameter int DATA_WIDTH = EVT_DATA_WIDTH,
  parameter int AWIDTH     = FIFO_AWIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AWIDTH-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**AWIDTH];

  // NOTE: the array has no reset; the pointers and occupancy counter decide
  // which entries are valid, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/event_fifo_irq.sv
// Event FIFO between the DVS event encoder and the SPI read path, with a
// saturating drop counter and a hysteresis interrupt to the host.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fifo_rst_n          : synchronous active-low soft clear
//   evt                 : event write handshake (slave side)
//   fifo_rd_en          : pop head word
//   rd_data             : head word, first-word-fall-through
//   fifo_numel          : registered occupancy
//   fifo_empty/full     : occupancy == 0 / occupancy == CAP
//   irq_assert_thresh   : interrupt assert level (0 disables the interrupt)
//   irq_deassert_thresh : interrupt deassert level
//   irq                 : interrupt to host
//   overflow, drop_cnt  : sticky drop flag, saturating dropped-event count
module event_fifo_irq
  import event_fifo_irq_pkg::*;
#(
  parameter int DATA_WIDTH     = EVT_DATA_WIDTH,
  parameter int AWIDTH         = FIFO_AWIDTH,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_rst_n,
  event_fifo_irq_if.slave           evt,
  input  logic                      fifo_rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [AWIDTH-1:0]         fifo_numel,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  input  logic [AWIDTH-1:0]         irq_assert_thresh,
  input  logic [AWIDTH-1:0]         irq_deassert_thresh,
  output logic                      irq,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  // Usable capacity is one less than the array depth so the occupancy fits
  // in AWIDTH bits; that value is simply all-ones.
  localparam logic [AWIDTH-1:0] CAP = '1;

  logic [AWIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0]         numel_q, numel_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  irq_state_e                irq_state_q, irq_state_d;

  logic wr_en, rd_en, drop;

  assign fifo_full  = (numel_q == CAP);
  assign fifo_empty = (numel_q == '0);

  // Gated by rst_n so the encoder sees a stall for the whole reset window.
  // A pop at full never frees a slot in the same cycle.
  assign evt.evt_ready = rst_n & fifo_rst_n & ~fifo_full;

  assign wr_en = evt.evt_valid & evt.evt_ready;
  assign rd_en = fifo_rd_en & ~fifo_empty & fifo_rst_n;
  assign drop  = evt.evt_valid & fifo_full & fifo_rst_n;

  event_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .AWIDTH     (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (evt.evt_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // block can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    numel_d    = numel_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (!fifo_rst_n) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      numel_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AWIDTH'(1);

      unique case ({wr_en, rd_en})
        2'b10:   numel_d = numel_q + AWIDTH'(1);
        2'b01:   numel_d = numel_q - AWIDTH'(1);
        default: numel_d = numel_q;
      endcase

      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  // Interrupt FSM looks at the registered occupancy, so irq trails the
  // occupancy change by one cycle.
  always_comb begin
    irq_state_d = irq_state_q;
    if (!fifo_rst_n) begin
      irq_state_d = IRQ_IDLE;
    end else begin
      unique case (irq_state_q)
        IRQ_IDLE: begin
          if ((irq_assert_thresh != '0) && (numel_q >= irq_assert_thresh))
            irq_state_d = IRQ_ASSERTED;
        end
        IRQ_ASSERTED: begin
          if ((numel_q <= irq_deassert_thresh) || (irq_assert_thresh == '0))
            irq_state_d = IRQ_IDLE;
        end
        default: irq_state_d = IRQ_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      numel_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      irq_state_q <= IRQ_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      numel_q     <= numel_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      irq_state_q <= irq_state_d;
    end
  end

  assign fifo_numel = numel_q;
  assign irq        = (irq_state_q == IRQ_ASSERTED);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_event_fifo_irq.sv
// Self-checking bench for event_fifo_irq at AWIDTH=3 (CAP=7) with a narrow
// drop counter so saturation is reachable. A queue-based model tracks the
// FIFO contents, drop state and interrupt; a compare process checks every
// output against it on each falling edge, and directed literal checks pin
// the key points of each scenario.
module tb_event_fifo_irq;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int DCW = 4;
  localparam int CAP = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rst_n;
  logic          fifo_rd_en;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] fifo_numel;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW-1:0] irq_assert_thresh;
  logic [AW-1:0] irq_deassert_thresh;
  logic          irq;
  logic          overflow;
  logic [DCW-1:0] drop_cnt;

  event_fifo_irq_if #(.DATA_WIDTH(DW)) evt_if ();

  event_fifo_irq #(
    .DATA_WIDTH     (DW),
    .AWIDTH         (AW),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fifo_rst_n          (fifo_rst_n),
    .evt                 (evt_if),
    .fifo_rd_en          (fifo_rd_en),
    .rd_data             (rd_data),
    .fifo_numel          (fifo_numel),
    .fifo_empty          (fifo_empty),
    .fifo_full           (fifo_full),
    .irq_assert_thresh   (irq_assert_thresh),
    .irq_deassert_thresh (irq_deassert_thresh),
    .irq                 (irq),
    .overflow            (overflow),
    .drop_cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            m_drop;
  bit            m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_irq  = 1'b0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs seen at it.
  task automatic model_update();
    int  n;
    bit  nxt_irq;
    n = mq.size();
    if (!fifo_rst_n) begin
      model_reset();
    end else begin
      if (irq_assert_thresh == 0)  nxt_irq = 1'b0;
      else if (!m_irq)             nxt_irq = (n >= int'(irq_assert_thresh));
      else                         nxt_irq = !(n <= int'(irq_deassert_thresh));
      if (fifo_rd_en && n != 0) void'(mq.pop_front());
      if (evt_if.evt_valid) begin
        if (n != CAP) mq.push_back(evt_if.evt_data);
        else begin
          m_ovf = 1'b1;
          if (m_drop < (2**DCW) - 1) m_drop++;
        end
      end
      m_irq = nxt_irq;
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are compared
  // at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #2;
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("numel",     32'(fifo_numel), 32'(mq.size()));
      check("empty",     32'(fifo_empty), 32'(mq.size() == 0));
      check("full",      32'(fifo_full),  32'(mq.size() == CAP));
      check("evt_ready", 32'(evt_if.evt_ready), 32'(fifo_rst_n && mq.size() != CAP));
      check("irq",       32'(irq),        32'(m_irq));
      check("overflow",  32'(overflow),   32'(m_ovf));
      check("drop_cnt",  32'(drop_cnt),   32'(m_drop));
      if (mq.size() != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_numel"},     32'(fifo_numel), 32'(0));
    check({tag, "_empty"},     32'(fifo_empty), 32'(1));
    check({tag, "_full"},      32'(fifo_full),  32'(0));
    check({tag, "_irq"},       32'(irq),        32'(0));
    check({tag, "_overflow"},  32'(overflow),   32'(0));
    check({tag, "_drop_cnt"},  32'(drop_cnt),   32'(0));
    check({tag, "_evt_ready"}, 32'(evt_if.evt_ready), 32'(0));
  endtask

  task automatic soft_clear();
    fifo_rst_n = 1'b0;
    tick();
    fifo_rst_n = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b1;
    fifo_rst_n          = 1'b1;
    fifo_rd_en          = 1'b0;
    evt_if.evt_valid    = 1'b0;
    evt_if.evt_data     = '0;
    irq_assert_thresh   = '0;
    irq_deassert_thresh = '0;
    model_reset();

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Fill to capacity, then drain in order.
    evt_if.evt_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      evt_if.evt_data = 16'(k * 16'h1111);
      tick();
    end
    check("fill_full",      32'(fifo_full),  32'(1));
    check("fill_numel",     32'(fifo_numel), 32'(7));
    check("fill_ready_low", 32'(evt_if.evt_ready), 32'(0));
    evt_if.evt_valid = 1'b0;
    fifo_rd_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      check("drain_order", 32'(rd_data), 32'(k * 16'h1111));
      tick();
    end
    fifo_rd_en = 1'b0;
    check("drain_empty", 32'(fifo_empty), 32'(1));

    // Overflow, drop counting, saturation, soft clear.
    evt_if.evt_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      evt_if.evt_data = 16'(16'hA000 + k);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      evt_if.evt_data = 16'(16'hBAD0 + k);
      tick();
    end
    evt_if.evt_valid = 1'b0;
    check("ovf_flag",  32'(overflow),   32'(1));
    check("ovf_drops", 32'(drop_cnt),   32'(3));
    check("ovf_head",  32'(rd_data),    32'(16'hA000));
    check("ovf_numel", 32'(fifo_numel), 32'(7));
    evt_if.evt_valid = 1'b1;
    repeat (14) tick();
    evt_if.evt_valid = 1'b0;
    check("drop_saturated", 32'(drop_cnt), 32'(15));
    soft_clear();
    check("clr_numel",    32'(fifo_numel), 32'(0));
    check("clr_overflow", 32'(overflow),   32'(0));
    check("clr_drop_cnt", 32'(drop_cnt),   32'(0));

    // Hysteresis: assert at 5, deassert at 2.
    irq_assert_thresh   = 3'd5;
    irq_deassert_thresh = 3'd2;
    evt_if.evt_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      evt_if.evt_data = 16'(16'hC000 + k);
      tick();
    end
    evt_if.evt_valid = 1'b0;
    check("hys_numel5_irq_lag", 32'(irq), 32'(0));
    tick();
    check("hys_irq_set", 32'(irq), 32'(1));
    fifo_rd_en = 1'b1;
    repeat (2) tick();
    fifo_rd_en = 1'b0;
    tick();
    check("hys_numel3_irq_held", 32'(irq), 32'(1));
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("hys_numel2_irq_lag", 32'(irq), 32'(1));
    tick();
    check("hys_irq_clear", 32'(irq), 32'(0));

    // Drain, including one pop while empty, then the disable threshold.
    fifo_rd_en = 1'b1;
    repeat (3) tick();
    fifo_rd_en = 1'b0;
    check("empty_pop_ignored", 32'(fifo_numel), 32'(0));
    irq_assert_thresh = 3'd0;
    evt_if.evt_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      evt_if.evt_data = 16'(16'hD000 + k);
      tick();
    end
    evt_if.evt_valid = 1'b0;
    repeat (2) tick();
    check("disabled_irq", 32'(irq), 32'(0));
    irq_assert_thresh = 3'd4;
    tick();
    check("enabled_irq", 32'(irq), 32'(1));

    // Simultaneous push/pop at empty and at full.
    soft_clear();
    check("clr_irq", 32'(irq), 32'(0));
    evt_if.evt_valid = 1'b1;
    evt_if.evt_data  = 16'hBEEF;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check("empty_rw_numel", 32'(fifo_numel), 32'(1));
    check("empty_rw_data",  32'(rd_data),    32'(16'hBEEF));
    for (int k = 0; k < 6; k++) begin
      evt_if.evt_data = 16'(16'hE000 + k);
      tick();
    end
    evt_if.evt_data = 16'hDEAD;
    fifo_rd_en = 1'b1;
    tick();
    evt_if.evt_valid = 1'b0;
    fifo_rd_en = 1'b0;
    check("full_rw_numel", 32'(fifo_numel), 32'(6));
    check("full_rw_drop",  32'(drop_cnt),   32'(1));
    check("full_rw_head",  32'(rd_data),    32'(16'hE000));

    // Async reset in the middle of a burst with irq asserted.
    soft_clear();
    irq_assert_thresh   = 3'd4;
    irq_deassert_thresh = 3'd1;
    evt_if.evt_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      evt_if.evt_data = 16'(16'hF000 + k);
      tick();
    end
    evt_if.evt_valid = 1'b0;
    tick();
    check("burst_numel", 32'(fifo_numel), 32'(4));
    check("burst_irq",   32'(irq),        32'(1));
    evt_if.evt_valid = 1'b1;
    evt_if.evt_data  = 16'hF004;
    #1 rst_n = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    evt_if.evt_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_numel", 32'(fifo_numel), 32'(0));

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
